// File: rtl/step_sequencer.sv
// step_sequencer: turns the sign flags of the step-count register into coil
// phase patterns and increment/decrement strobes. The sequencer runs at a
// programmable step rate and stops when the count reaches zero.
// Optional feature macro: STEP_SEQ_HALF_STEP_EN. When it is defined the
// sequencer half-steps through all 8 phases. When it is not defined the
// sequencer full-steps (two-phase-on) and uses only the odd phase indices.
module step_sequencer #(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       negative,
  input  logic       positive,
  input  logic       zero,
  output logic       increment,
  output logic       decrement,
  output logic [3:0] coils,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SETTLE
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

`ifdef STEP_SEQ_HALF_STEP_EN
  localparam logic [2:0] STEP = 3'd1;
`else
  localparam logic [2:0] STEP = 3'd2;
`endif

  state_t           state, state_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic [2:0]       index, index_next;
  logic             inc_next, dec_next;
  logic             fault_next;
  logic             legal;
  logic             moving;

  // Coil drive pattern for each phase index, in the order {A, B, A', B'}.
  function automatic logic [3:0] phase(input logic [2:0] idx);
    phase = 4'b0000;
    case (idx)
      3'd0: phase = 4'b1000;
      3'd1: phase = 4'b1100;
      3'd2: phase = 4'b0100;
      3'd3: phase = 4'b0110;
      3'd4: phase = 4'b0010;
      3'd5: phase = 4'b0011;
      3'd6: phase = 4'b0001;
      3'd7: phase = 4'b1001;
    endcase
  endfunction

  // A flag set is legal only when exactly one flag is high. An illegal set is treated as zero.
  assign legal  = (negative ^ positive ^ zero) & ~(negative & positive & zero);
  assign moving = legal & ~zero;

  // Next-state logic: step timing, direction, the strobes and the sticky fault.
  always_comb begin
    state_next = state;
    timer_next = timer;
    index_next = index;
    inc_next   = 1'b1;
    dec_next   = 1'b1;
    fault_next = fault;
    case (state)
      IDLE: begin
        timer_next = RELOAD;
        if (!legal) fault_next = 1'b1;
        if (enable && moving) state_next = RUN;
      end
      RUN: begin
        if (!legal) fault_next = 1'b1;
        if (!enable) begin
          state_next = IDLE;
          timer_next = RELOAD;
        end else if (timer == '0) begin
          timer_next = RELOAD;
          if (moving) begin
            state_next = SETTLE;
            if (positive) begin
              index_next = index + STEP;
              dec_next   = 1'b0;
            end else begin
              index_next = index - STEP;
              inc_next   = 1'b0;
            end
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer - CNT_W'(1);
        end
      end
      SETTLE: begin
        state_next = RUN;
      end
      default: begin
        state_next = IDLE;
        timer_next = RELOAD;
      end
    endcase
  end

  // State and output registers. Reset returns every output to idle at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= RELOAD;
      index     <= 3'd1;
      increment <= 1'b1;
      decrement <= 1'b1;
      coils     <= 4'b1100;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      index     <= index_next;
      increment <= inc_next;
      decrement <= dec_next;
      coils     <= phase(index_next);
      busy      <= (state_next != IDLE);
      fault     <= fault_next;
    end
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Sits directly downstream of the step-count register in the stepper-motor datapath. Reads its negative/positive/zero flags.
- Issues one active-low increment or decrement strobe per motor step, driving the remaining count toward zero.
- Generates the coil phase pattern for the motor driver at a programmable step rate. Goes idle when the count reaches zero.

Parameters:
- CLK_DIV, 50000, clock cycles per motor step (minimum 2).
- CNT_W, 32, width of the step-rate timer.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  active-high run permission
- negative  input  1  count < 0 flag from step-count register
- positive  input  1  count > 0 flag from step-count register
- zero  input  1  count == 0 flag from step-count register
- increment  output  1  active-low one-cycle strobe: count += 1
- decrement  output  1  active-low one-cycle strobe: count -= 1
- coils  output  4  coil drive pattern {A, B, A', B'}
- busy  output  1  high while in RUN or SETTLE
- fault  output  1  sticky flag: illegal flag combination seen

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n). All state is registered.
- Reset values:
  - increment = 1, decrement = 1, busy = 0, fault = 0.
  - Phase index = 1, so coils = 4'b1100. Timer = CLK_DIV-1. State = IDLE.
- Phase table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001. coils = table[index], registered.
- Direction and step size:
  - positive → forward: index += step, decrement strobe.
  - negative → reverse: index -= step, increment strobe.
  - step = 2 in full-step mode, 1 in half-step mode. Index arithmetic is mod 8 (wraps 7→0 / 0→7 etc.).
- Flag legality: exactly one of negative/positive/zero high. Any other combination is illegal:
  - Sets fault (cleared only by reset).
  - Treated as zero.
- States:
  - IDLE:
    - Timer held at CLK_DIV-1.
    - If enable && legal && !zero → RUN. Otherwise stay.
  - RUN:
    - Timer decrements each cycle.
    - If enable drops → IDLE immediately. Timer reloads; coils hold the current pattern for holding torque.
    - When timer == 0 and flags are still nonzero and legal:
      - Advance index.
      - Pulse exactly one strobe for one cycle.
      - Reload timer.
      - → SETTLE.
    - When timer == 0 and flags read zero/illegal → IDLE with no step.
  - SETTLE: one cycle, lets the register update its flags; flags are ignored this cycle. → RUN.
- Latency:
  - First step occurs exactly CLK_DIV cycles after entering RUN.
  - Subsequent steps occur every CLK_DIV+1 cycles (includes SETTLE).
  - coils change on the same edge the strobe asserts.
- Simultaneous events:
  - enable falling on the cycle timer hits 0 → no step, go IDLE.
  - Flags changing sign mid-RUN (external reload) → direction is taken from the flags at the step edge.
- reset_n asserted mid-operation → all outputs return to reset values asynchronously; no partial strobe.
- increment and decrement are never low in the same cycle.

Optional Feature:
- Macro: STEP_SEQ_HALF_STEP_EN.
- Defined: half-step mode. step = 1; all 8 table entries are used; one motor step = one count.
- Undefined: full-step mode (two-phase-on). step = 2; only odd indices are used (1100, 0110, 0011, 1001); index stays odd at all times.

Test Plan:
- Reset mid-RUN, CLK_DIV=4, positive=1, enable=1: pulse reset_n low after 2 steps → coils=1100, strobes high, busy=0, fault=0 immediately. After release → first step 4 cycles later.
- Forward run, CLK_DIV=4, full-step: bench model register starts at +3, enable=1. Required response:
  - Exactly 3 decrement pulses, spaced 5 cycles apart.
  - coils sequence 1100→0110→0011→1001.
  - busy drops when zero=1; increment stays high.
- Reverse wrap, half-step macro, register at −3, index 1: 3 increment pulses; coils 1100→1000→1001→0001 (index 1→0→7→6).
- Enable abort: enable dropped 2 cycles into RUN → IDLE next edge, no strobe, coils unchanged. Re-enable → full CLK_DIV wait before the first step.
- Illegal flags: positive=1 and negative=1 while enable=1 → fault=1 and stays 1, no strobes, state IDLE. fault remains set after the flags return legal, until reset_n.
